// File: rtl/simple_isa_pkg.sv
// Shared ISA constants and issue-stage types for the 16-bit pipeline.
// Consumed by the issue unit and its history registers.
package simple_isa_pkg;

  localparam logic [15:0] BUBBLE  = 16'hC0E0;
  localparam logic [1:0]  OPC_ALU = 2'b11;
  localparam logic [3:0]  ALU_HLT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    HALT
  } issue_state_t;

  function automatic logic is_hlt(input logic [15:0] w);
    return (w[15:14] == OPC_ALU) && (w[7:4] == ALU_HLT);
  endfunction

endpackage

// File: rtl/issue_history_regs.sv
// Three-slot issue history (cur, prev1, prev2) plus valid of cur.
// Reset and bubbles fill slots with the BUBBLE word.
module issue_history_regs
  import simple_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  input  logic [15:0] new_word,
  input  logic        new_valid,
  output logic [15:0] cur,
  output logic [15:0] prev1,
  output logic [15:0] prev2,
  output logic        cur_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= BUBBLE;
      prev1     <= BUBBLE;
      prev2     <= BUBBLE;
      cur_valid <= 1'b0;
    end else if (shift_en) begin
      prev2     <= prev1;
      prev1     <= cur;
      cur       <= new_word;
      cur_valid <= new_valid;
    end
  end

endmodule

// File: rtl/instruction_issue_unit.sv
// Fetch/issue front end: PC, fetch FSM, branch shadow and HLT stop.
// Define ISSUE_PERF_CNT_EN to build the saturating issue/bubble counters.
module instruction_issue_unit
  import simple_isa_pkg::*;
#(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int          BRANCH_SHADOW = 2,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [15:0]      imem_addr,
  output logic             imem_req,
  input  logic [15:0]      imem_rdata,
  input  logic             imem_valid,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [15:0]      br_target,
  output logic [15:0]      cmd_cur,
  output logic [15:0]      cmd_prev1,
  output logic [15:0]      cmd_prev2,
  output logic             cmd_valid,
  output logic             halted,
  output logic [CNT_W-1:0] issue_count,
  output logic [CNT_W-1:0] bubble_count
);

  localparam int FW =
    (BRANCH_SHADOW < 2) ? 1 : $clog2(BRANCH_SHADOW);
  localparam logic [FW-1:0] SHADOW_LOAD =
    FW'(BRANCH_SHADOW - 1);

  issue_state_t    state;
  logic [15:0]     pc;
  logic [FW-1:0]   flush_cnt;
  logic            consume;
  logic            advance;
  logic [15:0]     new_word;

  assign imem_addr = pc;
  assign imem_req  = (state == RUN);

  // Branch wins over stall and drops any word pending for the old PC
  assign consume  = (state == RUN) & imem_valid
                  & ~stall & ~br_taken;
  assign advance  = br_taken | ~stall;
  assign new_word = consume ? imem_rdata : BUBBLE;

  issue_history_regs u_hist (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (advance),
    .new_word  (new_word),
    .new_valid (consume),
    .cur       (cmd_cur),
    .prev1     (cmd_prev1),
    .prev2     (cmd_prev2),
    .cur_valid (cmd_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      flush_cnt <= '0;
      halted    <= 1'b0;
    end else if (br_taken) begin
      pc        <= br_target;
      halted    <= 1'b0;
      flush_cnt <= SHADOW_LOAD;
      state     <= (BRANCH_SHADOW > 1) ? FLUSH : RUN;
    end else begin
      unique case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (consume) begin
            pc <= pc + 16'd1;
            if (is_hlt(imem_rdata)) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!stall) begin
            flush_cnt <= flush_cnt - FW'(1);
            if (flush_cnt <= FW'(1))
              state <= RUN;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0] issue_q;
  logic [CNT_W-1:0] bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q  <= '0;
      bubble_q <= '0;
    end else if (advance) begin
      if (consume) begin
        if (!(&issue_q))
          issue_q <= issue_q + CNT_W'(1);
      end else if (!(&bubble_q)) begin
        bubble_q <= bubble_q + CNT_W'(1);
      end
    end
  end

  assign issue_count  = issue_q;
  assign bubble_count = bubble_q;
`else
  assign issue_count  = '0;
  assign bubble_count = '0;
`endif

endmodule
